// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter with a push-side FIFO. Upstream pushes words with a
//   valid/ready handshake; the FSM pops them and serialises each as
//   start bit, DATA_BITS data bits (LSB first), optional parity bit, and
//   STOP_BITS stop bits. Every bit lasts BAUD_DIV = CLK_FREQ / BAUD_RATE cycles.
//
// Ports
//   clk         system clock
//   rst_n       synchronous active-low reset
//   tx_valid    upstream word on tx_data is valid
//   tx_data     word to send, sampled only when it is pushed
//   tx_ready    FIFO can accept a word (occupancy below FIFO_DEPTH)
//   tx          serial line, idle high, registered
//   tx_busy     FIFO non-empty or a frame is in flight
//   tx_done     one-cycle pulse during the final cycle of each frame's last stop bit
//   fifo_count  current FIFO occupancy
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tx_valid,
    input  logic [DATA_BITS-1:0]        tx_data,
    output logic                        tx_ready,
    output logic                        tx,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int BIT_W    = $clog2(DATA_BITS);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic [DATA_BITS-1:0] shreg;
    logic [CNT_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic                 par_bit;
    logic                 baud_term;
    logic                 last_stop;
    logic                 push;
    logic                 pop;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    assign tx_ready  = (fifo_count != FULL);
    assign push      = tx_valid && tx_ready;
    assign head      = mem[rd_ptr];
    assign baud_term = (baud_cnt == CNT_W'(BAUD_DIV - 1));
    assign last_stop = (bit_idx == BIT_W'(STOP_BITS - 1));

    // Pop from IDLE, or at the last stop-bit terminal so frames run back-to-back.
    always_comb begin
        pop = 1'b0;
        if (fifo_count != '0)
            pop = (state == IDLE) || ((state == STOP) && baud_term && last_stop);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
        end
    end

    // Line outputs are registered from the state held before each edge, so
    // the pin trails the FSM by one cycle and every bit keeps a full BAUD_DIV.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_busy <= (state != IDLE) || (fifo_count != '0);
            if (state != IDLE)
                baud_cnt <= baud_term ? '0 : baud_cnt + 1'b1;

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shreg    <= head;
                        par_bit  <= parity_of(head);
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_term) begin
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    tx <= shreg[0];
                    if (baud_term) begin
                        shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? PAR : STOP;
                        end
                    end
                end
                PAR: begin
                    tx <= par_bit;
                    if (baud_term)
                        state <= STOP;
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_term) begin
                        bit_idx <= bit_idx + 1'b1;
                        if (last_stop) begin
                            tx_done <= 1'b1;
                            bit_idx <= '0;
                            if (pop) begin
                                shreg   <= head;
                                par_bit <= parity_of(head);
                                state   <= START;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parameterisations (8N1 depth 4, 8E1, 8O2, 5N1),
// BAUD_DIV = 10. Stimulus pushes expected words into a queue; a per-instance
// line monitor decodes each frame cycle by cycle and compares it against the
// frame built from the word by plain arithmetic.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int BD        = CLK_FREQ / BAUD_RATE;
    localparam int NCFG      = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit blk_done [NCFG];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int cfg_db(input int i);
        return (i == 3) ? 5 : 8;
    endfunction
    function automatic int cfg_par(input int i);
        return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
    endfunction
    function automatic int cfg_sb(input int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic int cfg_dep(input int i);
        return (i == 0) ? 4 : 16;
    endfunction
    function automatic int first_word(input int i);
        return (i == 0) ? 'h55 : ((i == 3) ? 'h13 : 'h07);
    endfunction

    for (genvar I = 0; I < NCFG; I++) begin : g
        localparam int DB   = cfg_db(I);
        localparam int PB   = cfg_par(I);
        localparam int SB   = cfg_sb(I);
        localparam int DEP  = cfg_dep(I);
        localparam int NB   = 1 + DB + ((PB != 0) ? 1 : 0) + SB;
        localparam int FLEN = BD * NB;
        localparam int CW   = $clog2(DEP) + 1;
        localparam int MASK = (1 << DB) - 1;

        logic          rst_n;
        logic          tx_valid;
        logic [DB-1:0] tx_data;
        logic          tx_ready;
        logic          tx;
        logic          tx_busy;
        logic          tx_done;
        logic [CW-1:0] fifo_count;

        int exp_q  [$];
        int starts [$];
        int dones  [$];
        int acc_cyc;

        uart_tx_fifo #(
            .CLK_FREQ  (CLK_FREQ),
            .BAUD_RATE (BAUD_RATE),
            .DATA_BITS (DB),
            .PARITY    (PB),
            .STOP_BITS (SB),
            .FIFO_DEPTH(DEP)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .tx_valid  (tx_valid),
            .tx_data   (tx_data),
            .tx_ready  (tx_ready),
            .tx        (tx),
            .tx_busy   (tx_busy),
            .tx_done   (tx_done),
            .fifo_count(fifo_count)
        );

        // Reference frame: bit k of the frame for word w.
        function automatic int line_bit(input int w, input int k);
            int ones;
            if (k == 0) return 0;
            if (k <= DB) return (w >> (k - 1)) & 1;
            if (PB != 0 && k == DB + 1) begin
                ones = $countones(w & MASK);
                return (PB == 2) ? (ones % 2) : (1 - (ones % 2));
            end
            return 1;
        endfunction

        task automatic push(input int w);
            bit ok;
            ok = 1'b0;
            tx_valid = 1'b1;
            tx_data  = DB'(w);
            for (int t = 0; t < 3 * FLEN && !ok; t++) begin
                if (tx_ready === 1'b1) begin
                    exp_q.push_back(w & MASK);
                    ok = 1'b1;
                end
                @(negedge clk);
                if (ok) acc_cyc = cyc;
            end
            tx_valid = 1'b0;
            if (!ok) chk($sformatf("cfg%0d push_timeout", I), 0, 1);
        endtask

        task automatic wait_done(input string tag);
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 3 * FLEN && !seen; t++) begin
                @(negedge clk);
                if (tx_done === 1'b1) seen = 1'b1;
            end
            if (!seen) chk($sformatf("cfg%0d %s_timeout", I, tag), 0, 1);
        endtask

        task automatic wait_idle(input string tag);
            bit idle;
            idle = 1'b0;
            for (int t = 0; t < 40 * FLEN && !idle; t++) begin
                @(negedge clk);
                idle = (exp_q.size() == 0) && (tx_busy === 1'b0);
            end
            chk($sformatf("cfg%0d %s_drained", I, tag), 32'(idle), 1);
        endtask

        task automatic chk_quiet(input string tag);
            chk($sformatf("cfg%0d %s_tx", I, tag), 32'(tx), 1);
            chk($sformatf("cfg%0d %s_busy", I, tag), 32'(tx_busy), 0);
            chk($sformatf("cfg%0d %s_done", I, tag), 32'(tx_done), 0);
            chk($sformatf("cfg%0d %s_count", I, tag), 32'(fifo_count), 0);
            chk($sformatf("cfg%0d %s_ready", I, tag), 32'(tx_ready), 1);
        endtask

        // Line monitor: a frame starts when the idle-high line drops.
        initial begin : mon
            int w, rx, expb, terr, derr;
            bit aborted;
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1 && tx === 1'b1 && tx_done === 1'b1)
                    chk($sformatf("cfg%0d spurious_done", I), 1, 0);
                if (rst_n === 1'b1 && tx === 1'b0) begin
                    starts.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        chk($sformatf("cfg%0d unexpected_frame", I), 1, 0);
                        repeat (FLEN - 1) @(negedge clk);
                    end else begin
                        w = exp_q.pop_front();
                        rx = 0; terr = 0; derr = 0; aborted = 1'b0;
                        expb = 0;
                        for (int b = 0; b < NB; b++) expb |= line_bit(w, b) << b;
                        for (int k = 0; k < FLEN; k++) begin
                            if (k > 0) @(negedge clk);
                            if (rst_n !== 1'b1) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (tx !== 1'(line_bit(w, k / BD))) terr++;
                            if (tx_busy !== 1'b1) terr++;
                            if (tx_done !== (k == FLEN - 1)) derr++;
                            if (k % BD == BD / 2) rx |= ((tx === 1'b1) ? 1 : 0) << (k / BD);
                        end
                        if (!aborted) begin
                            dones.push_back(cyc);
                            chk($sformatf("cfg%0d frame_bits w=%0h", I, w), rx, expb);
                            chk($sformatf("cfg%0d frame_timing w=%0h", I, w), terr, 0);
                            chk($sformatf("cfg%0d done_pulse w=%0h", I, w), derr, 0);
                        end
                    end
                end
            end
        end

        initial begin : stim
            int a0, s, nst, ec;
            int acc [$];
            rst_n = 1'b0;
            tx_valid = 1'b0;
            tx_data = '0;
            repeat (3) @(negedge clk);
            chk_quiet("reset");
            rst_n = 1'b1;
            @(negedge clk);

            // Single frame: latency, line pattern, length.
            push(first_word(I));
            a0 = acc_cyc;
            wait_done("frame1");
            @(negedge clk);
            chk($sformatf("cfg%0d idle_busy", I), 32'(tx_busy), 0);
            if (starts.size() > 0 && dones.size() > 0) begin
                chk($sformatf("cfg%0d start_latency", I), starts[0] - a0, 2);
                chk($sformatf("cfg%0d frame_len", I), dones[0] - starts[0] + 1, FLEN);
            end else begin
                chk($sformatf("cfg%0d frame1_seen", I), 0, 1);
            end

            // Back-to-back: three consecutive pushes.
            starts.delete();
            dones.delete();
            push('hA0);
            push('h0F);
            push('hFF);
            chk($sformatf("cfg%0d b2b_count", I), 32'(fifo_count), 2);
            for (int f = 0; f < 3; f++) begin
                wait_done("b2b");
                ec = (exp_q.size() > 0) ? exp_q.size() - 1 : 0;
                chk($sformatf("cfg%0d b2b_pop_count%0d", I, f), 32'(fifo_count), ec);
            end
            @(negedge clk);
            chk($sformatf("cfg%0d b2b_busy_end", I), 32'(tx_busy), 0);
            if (starts.size() >= 3 && dones.size() >= 3) begin
                chk($sformatf("cfg%0d b2b_gap1", I), starts[1], dones[0] + 1);
                chk($sformatf("cfg%0d b2b_gap2", I), starts[2], dones[1] + 1);
            end else begin
                chk($sformatf("cfg%0d b2b_frames", I), starts.size(), 3);
            end

            // Full FIFO: hold valid for DEP+2 words.
            starts.delete();
            dones.delete();
            for (int k = 1; k <= DEP + 2; k++) begin
                push(int'($urandom));
                acc.push_back(acc_cyc);
                if (k == DEP + 1) begin
                    chk($sformatf("cfg%0d full_count", I), 32'(fifo_count), DEP);
                    chk($sformatf("cfg%0d full_ready", I), 32'(tx_ready), 0);
                end
            end
            chk($sformatf("cfg%0d full_burst", I), acc[DEP] - acc[0], DEP);
            if (dones.size() > 0)
                chk($sformatf("cfg%0d full_resume", I), acc[DEP + 1], dones[0] + 1);
            else
                chk($sformatf("cfg%0d full_first_done", I), 0, 1);
            wait_idle("full");

            // Reset during data bit 3 with two words queued.
            starts.delete();
            dones.delete();
            push('h3C);
            push(int'($urandom));
            push(int'($urandom));
            for (int t = 0; t < 4 * BD && starts.size() == 0; t++) @(negedge clk);
            if (starts.size() == 0) begin
                chk($sformatf("cfg%0d rst_frame_start", I), 0, 1);
                s = cyc;
            end else begin
                s = starts[0];
            end
            while (cyc < s + BD * 4 + BD / 2) @(negedge clk);
            rst_n = 1'b0;
            exp_q.delete();
            @(negedge clk);
            chk_quiet("mid_reset");
            @(negedge clk);
            rst_n = 1'b1;
            nst = starts.size();
            repeat (2 * FLEN) @(negedge clk);
            chk($sformatf("cfg%0d post_reset_frames", I), starts.size(), nst);
            chk($sformatf("cfg%0d post_reset_tx", I), 32'(tx), 1);

            // Random traffic with random gaps.
            for (int n = 0; n < 12; n++) begin
                push(int'($urandom));
                if ($urandom_range(0, 3) == 0)
                    repeat ($urandom_range(0, 2 * FLEN)) @(negedge clk);
                else
                    repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wait_idle("random");
            chk($sformatf("cfg%0d final_count", I), 32'(fifo_count), 0);
            blk_done[I] = 1'b1;
        end
    end

    initial begin : top
        bit all_done;
        all_done = 1'b0;
        for (int t = 0; t < 60000 && !all_done; t++) begin
            @(negedge clk);
            all_done = 1'b1;
            for (int i = 0; i < NCFG; i++)
                if (!blk_done[i]) all_done = 1'b0;
        end
        if (!all_done) chk("global_timeout", 0, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter for the matrix calculator's serial result path. It adds a push-side FIFO with a valid/ready handshake, a configurable data width, optional odd/even parity, and 1 or 2 stop bits. Upstream formatters push bytes without waiting for each frame to finish. The block drives the board TX pin directly.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; BAUD_DIV = CLK_FREQ / BAUD_RATE (integer division), legal range 2..65535
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 16, FIFO entries, power of two, at least 2

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous and active-low
tx_valid  input  1  upstream has a word on tx_data
tx_data  input  DATA_BITS  word to send
tx_ready  output  1  FIFO can accept a word; high when fifo_count < FIFO_DEPTH
tx  output  1  serial line, idle high
tx_busy  output  1  high when the FIFO is non-empty or a frame is in flight
tx_done  output  1  one-cycle pulse at the end of each frame's last stop bit
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low at a clk edge): tx=1, tx_busy=0, tx_done=0, fifo_count=0, tx_ready=1. FIFO pointers and the baud counter clear. FSM goes to IDLE. A frame in flight is abandoned, and tx is high from the next edge.
- Push: a word is written on any edge where tx_valid && tx_ready. tx_ready depends only on the registered count. There is no full-bypass: a simultaneous push and pop when full is not accepted.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: if the FIFO is non-empty, pop the head into the shift register, clear the baud counter, and go to START.
- Latency: the word pushed at edge N into an empty FIFO with the FSM in IDLE pops at edge N+1. tx goes low after edge N+2.
- Bit timing: every bit, including the start bit, lasts exactly BAUD_DIV cycles. The baud counter runs 0..BAUD_DIV-1, and the bit advances when it reaches BAUD_DIV-1.
- START: tx=0, then go to DATA.
- DATA: send DATA_BITS bits LSB first. After the last bit, go to PAR if PARITY!=0, otherwise go to STOP.
- PAR: tx = XOR of the data bits for even parity, or its inverse for odd parity. The total count of ones across data plus parity is even or odd respectively.
- STOP: tx=1 for STOP_BITS × BAUD_DIV cycles. At the final counter terminal, tx_done pulses for one cycle.
- At the end of STOP, if the FIFO is non-empty, pop in the same cycle and go directly to START. There is no idle gap between back-to-back frames. Otherwise go to IDLE.
- Frame length: BAUD_DIV × (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) cycles.
- tx is registered and glitch-free. tx_data is sampled only at push; later changes do not affect queued words.
- fifo_count on the same edge: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Pointers wrap modulo FIFO_DEPTH.

Test Plan:
1. Reset and idle:
   - Stimulus: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (BAUD_DIV=10), 8N1. Push 0x55.
   - Required: tx low from 2 edges after the push.
   - Required line sequence in 10-cycle bits: 0,1,0,1,0,1,0,1,0,1.
   - Required: tx_done pulses 100 cycles after the start bit begins.
2. Parity:
   - Even parity, push 0x07: parity bit = 1, frame length 110 cycles.
   - Odd parity, push 0x07: parity bit = 0.
   - 2 stop bits: line high for 20 cycles before tx_done.
3. Back-to-back: push 0xA0, 0x0F, 0xFF on consecutive cycles.
   - Required: three contiguous frames with no idle cycles between them.
   - Required: tx_busy high throughout and low the cycle after the third tx_done.
   - Required: fifo_count reads 2, then 1, then 0 at the pops.
4. Full FIFO: FIFO_DEPTH=4, tx_valid held for words 1..6.
   - Required: words 1..5 accepted (word 1 goes to the shifter).
   - Required: tx_ready low while fifo_count=4; word 6 accepted the cycle after the first frame's pop.
   - Required: all six words transmitted in order.
5. Reset mid-frame: assert rst_n low during data bit 3 of 0x3C with 2 words queued.
   - Required: tx=1 after the edge, fifo_count=0, tx_busy=0.
   - Required: after rst_n is released, no further frames are sent.
6. DATA_BITS=5, push 5'h13:
   - Required line bits 0,1,1,0,0,1,1.
   - Required: frame length 70 cycles.
